// File: rtl/nes_bus_pkg.sv
// Shared types and address map for the NES CPU-side bus fabric.
//   bus_state_e  : arbitration FSM states
//   slave_e      : read-data source selected by the address decoder
//   decode_slave : maps a 16-bit bus address to its slave
package nes_bus_pkg;

  typedef enum logic [2:0] {StIdle, StHalt, StGrant, StRearb, StRelease} bus_state_e;

  typedef enum logic [2:0] {SlvRam, SlvPpu, SlvApu, SlvJpd, SlvOpen, SlvMmc} slave_e;

  localparam logic [15:0] RamBase   = 16'h0000;
  localparam logic [15:0] RamLimit  = 16'h1FFF;
  localparam logic [15:0] PpuBase   = 16'h2000;
  localparam logic [15:0] PpuLimit  = 16'h3FFF;
  localparam logic [15:0] ApuBase   = 16'h4000;
  localparam logic [15:0] ApuLimit  = 16'h4015;
  localparam logic [15:0] JpdBase   = 16'h4016;
  localparam logic [15:0] JpdLimit  = 16'h4017;
  localparam logic [15:0] OpenBase  = 16'h4018;
  localparam logic [15:0] OpenLimit = 16'h401F;
  localparam logic [15:0] MmcBase   = 16'h4020;
  localparam logic [15:0] MmcLimit  = 16'hFFFF;

  function automatic logic in_range(input logic [15:0] addr, input logic [15:0] base,
                                    input logic [15:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

  function automatic slave_e decode_slave(input logic [15:0] addr);
    slave_e slv;
    if (in_range(addr, RamBase, RamLimit))        slv = SlvRam;
    else if (in_range(addr, PpuBase, PpuLimit))   slv = SlvPpu;
    else if (in_range(addr, ApuBase, ApuLimit))   slv = SlvApu;
    else if (in_range(addr, JpdBase, JpdLimit))   slv = SlvJpd;
    else if (in_range(addr, OpenBase, OpenLimit)) slv = SlvOpen;
    else if (in_range(addr, MmcBase, MmcLimit))   slv = SlvMmc;
    else                                          slv = SlvOpen;
    return slv;
  endfunction

endpackage

// File: rtl/nes_bus_arb.sv
// Combinational DMA winner select.
//   req_i    : per-master request vector
//   ptr_i    : index of the last granted master (round-robin mode only)
//   onehot_o : one-hot winner, zero when nobody requests
//   idx_o    : binary winner index
//   valid_o  : some master requests
module nes_bus_arb #(
  parameter int unsigned NUM_DMA  = 2,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned IDX_W    = 1
) (
  input  logic [NUM_DMA-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_DMA-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // Fixed priority is round-robin that always restarts after the top index, so index 0 leads.
  logic [IDX_W-1:0] start;
  logic             found_hi, found_lo;
  logic [IDX_W-1:0] idx_hi, idx_lo;

  assign start = (ARB_MODE == 1) ? ptr_i : IDX_W'(NUM_DMA - 1);

  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    // Descending scan: the last hit in each half is its lowest requesting index.
    for (int i = NUM_DMA - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        if (i > int'(start)) begin
          found_hi = 1'b1;
          idx_hi   = IDX_W'(i);
        end else begin
          found_lo = 1'b1;
          idx_lo   = IDX_W'(i);
        end
      end
    end
    valid_o  = found_hi | found_lo;
    idx_o    = found_hi ? idx_hi : idx_lo;
    onehot_o = '0;
    if (valid_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/nes_bus_mx.sv
// CPU-side NES bus fabric: the 6502 and NUM_DMA DMA masters share one 16-bit bus.
//   i_clk, i_rstn                      : clock, synchronous active-low reset
//   o_cpu_pause                        : halts the CPU while DMA owns the bus (registered)
//   i_cpu_addr/_r_wn/_wdata, o_cpu_rdata : CPU bus side (r_wn 1 = read)
//   i_dma_req/_addr/_wn/_wdata         : packed per-master DMA requests (wn 1 = read)
//   o_dma_gnt, o_dma_rdata             : one-hot grant (registered), read data to owner
//   o_bus_addr/_wdata/_wn              : shared bus toward the slaves (wn 0 = write)
//   i_{ram,ppu,apu,jpd,mmc}_rdata      : slave read data, valid in the same cycle
module nes_bus_mx
  import nes_bus_pkg::*;
#(
  parameter int unsigned NUM_DMA   = 2,
  parameter int unsigned ARB_MODE  = 0,
  parameter int unsigned MAX_BURST = 256,
  parameter logic [15:0] PARK_ADDR = 16'h0000
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  output logic                   o_cpu_pause,
  input  logic [15:0]            i_cpu_addr,
  input  logic                   i_cpu_r_wn,
  input  logic [7:0]             i_cpu_wdata,
  output logic [7:0]             o_cpu_rdata,
  input  logic [NUM_DMA-1:0]     i_dma_req,
  output logic [NUM_DMA-1:0]     o_dma_gnt,
  input  logic [16*NUM_DMA-1:0]  i_dma_addr,
  input  logic [NUM_DMA-1:0]     i_dma_wn,
  input  logic [8*NUM_DMA-1:0]   i_dma_wdata,
  output logic [7:0]             o_dma_rdata,
  output logic [15:0]            o_bus_addr,
  output logic [7:0]             o_bus_wdata,
  output logic                   o_bus_wn,
  input  logic [7:0]             i_ram_rdata,
  input  logic [7:0]             i_ppu_rdata,
  input  logic [7:0]             i_apu_rdata,
  input  logic [7:0]             i_jpd_rdata,
  input  logic [7:0]             i_mmc_rdata
);

  localparam int unsigned IdxW = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;
  localparam int unsigned CntW = $clog2(MAX_BURST);

  bus_state_e       state_q, state_d;
  logic             pause_q, pause_d;
  logic [NUM_DMA-1:0] gnt_q, gnt_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Last winner; during GRANT it is also the current owner.
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [7:0]       latch_q;

  logic [NUM_DMA-1:0] arb_onehot;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_valid;

  logic        parked, cpu_owner, bus_wn_raw, bus_read;
  logic [7:0]  mux_data;

  nes_bus_arb #(
    .NUM_DMA  (NUM_DMA),
    .ARB_MODE (ARB_MODE),
    .IDX_W    (IdxW)
  ) u_arb (
    .req_i    (i_dma_req),
    .ptr_i    (ptr_q),
    .onehot_o (arb_onehot),
    .idx_o    (arb_idx),
    .valid_o  (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    pause_d = pause_q;
    gnt_d   = '0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        pause_d = 1'b0;
        // Only halt on a CPU read; the 6502 cannot be stopped mid-write.
        if ((|i_dma_req) && i_cpu_r_wn) begin
          state_d = StHalt;
          pause_d = 1'b1;
        end
      end
      StHalt, StRearb: begin
        if (arb_valid) begin
          state_d = StGrant;
          gnt_d   = arb_onehot;
          ptr_d   = arb_idx;
          cnt_d   = '0;
        end else begin
          state_d = StRelease;
          pause_d = 1'b0;
        end
      end
      StGrant: begin
        if (!i_dma_req[ptr_q]) begin
          state_d = StRearb;
        end else if (cnt_q == CntW'(MAX_BURST - 1)) begin
          state_d = StRelease;
          pause_d = 1'b0;
        end else begin
          gnt_d = gnt_q;
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        state_d = StIdle;
        pause_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
        pause_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= StIdle;
      pause_q <= 1'b0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      latch_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pause_q <= pause_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      if (bus_read) latch_q <= mux_data;
    end
  end

  // Bus owner mux.
  always_comb begin
    o_bus_addr  = i_cpu_addr;
    o_bus_wdata = i_cpu_wdata;
    bus_wn_raw  = i_cpu_r_wn;
    parked      = 1'b0;
    cpu_owner   = 1'b0;
    unique case (state_q)
      StGrant: begin
        for (int k = 0; k < NUM_DMA; k++) begin
          if (ptr_q == IdxW'(k)) begin
            o_bus_addr  = i_dma_addr[16*k +: 16];
            o_bus_wdata = i_dma_wdata[8*k +: 8];
            bus_wn_raw  = i_dma_wn[k];
          end
        end
      end
      StHalt, StRearb: begin
        o_bus_addr  = PARK_ADDR;
        o_bus_wdata = 8'h00;
        bus_wn_raw  = 1'b1;
        parked      = 1'b1;
      end
      default: cpu_owner = 1'b1;
    endcase
  end

  // A cycle with reset asserted never issues a write, whoever owned the bus.
  assign o_bus_wn = bus_wn_raw | ~i_rstn;
  assign bus_read = ~parked & o_bus_wn;

  always_comb begin
    mux_data = latch_q;
    unique case (decode_slave(o_bus_addr))
      SlvRam:  mux_data = i_ram_rdata;
      SlvPpu:  mux_data = i_ppu_rdata;
      SlvApu:  mux_data = i_apu_rdata;
      SlvJpd:  mux_data = i_jpd_rdata;
      SlvMmc:  mux_data = i_mmc_rdata;
      default: mux_data = latch_q;
    endcase
  end

  assign o_dma_rdata = mux_data;
  assign o_cpu_rdata = cpu_owner ? mux_data : latch_q;
  assign o_cpu_pause = pause_q;
  assign o_dma_gnt   = gnt_q;

endmodule

// File: tb/tb_nes_bus_mx.sv
module tb_nes_bus_mx;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] cpu_addr;
  logic        cpu_r_wn;
  logic [7:0]  cpu_wdata;
  logic [1:0]  req_f, req_r;
  logic [31:0] dma_addr;
  logic [1:0]  dma_wn;
  logic [15:0] dma_wdata;
  logic [7:0]  ram, ppu, apu, jpd, mmc;

  logic        pause_f, pause_r, bus_wn_f, bus_wn_r;
  logic [1:0]  gnt_f, gnt_r;
  logic [7:0]  cpu_rdata_f, cpu_rdata_r, dma_rdata_f, dma_rdata_r, bus_wdata_f, bus_wdata_r;
  logic [15:0] bus_addr_f, bus_addr_r;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  nes_bus_mx #(.NUM_DMA(2), .ARB_MODE(0), .MAX_BURST(256), .PARK_ADDR(16'h0000)) u_fix (
    .i_clk(clk), .i_rstn(rstn), .o_cpu_pause(pause_f),
    .i_cpu_addr(cpu_addr), .i_cpu_r_wn(cpu_r_wn), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata_f), .i_dma_req(req_f), .o_dma_gnt(gnt_f),
    .i_dma_addr(dma_addr), .i_dma_wn(dma_wn), .i_dma_wdata(dma_wdata),
    .o_dma_rdata(dma_rdata_f), .o_bus_addr(bus_addr_f), .o_bus_wdata(bus_wdata_f),
    .o_bus_wn(bus_wn_f), .i_ram_rdata(ram), .i_ppu_rdata(ppu), .i_apu_rdata(apu),
    .i_jpd_rdata(jpd), .i_mmc_rdata(mmc)
  );

  nes_bus_mx #(.NUM_DMA(2), .ARB_MODE(1), .MAX_BURST(256), .PARK_ADDR(16'h0000)) u_rr (
    .i_clk(clk), .i_rstn(rstn), .o_cpu_pause(pause_r),
    .i_cpu_addr(cpu_addr), .i_cpu_r_wn(cpu_r_wn), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata_r), .i_dma_req(req_r), .o_dma_gnt(gnt_r),
    .i_dma_addr(dma_addr), .i_dma_wn(dma_wn), .i_dma_wdata(dma_wdata),
    .o_dma_rdata(dma_rdata_r), .o_bus_addr(bus_addr_r), .o_bus_wdata(bus_wdata_r),
    .o_bus_wn(bus_wn_r), .i_ram_rdata(ram), .i_ppu_rdata(ppu), .i_apu_rdata(apu),
    .i_jpd_rdata(jpd), .i_mmc_rdata(mmc)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  exp;
  } dec_vec_t;

  dec_vec_t dec_tab [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    req_f    = 2'b00;
    req_r    = 2'b00;
    cpu_r_wn = 1'b1;
    cpu_addr = 16'h0100;
    repeat (cycles) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    dec_tab[0]  = '{16'h0000, 8'h11};
    dec_tab[1]  = '{16'h1FFF, 8'h11};
    dec_tab[2]  = '{16'h2000, 8'h22};
    dec_tab[3]  = '{16'h3FFF, 8'h22};
    dec_tab[4]  = '{16'h4000, 8'h33};
    dec_tab[5]  = '{16'h4015, 8'h33};
    dec_tab[6]  = '{16'h4016, 8'h44};
    dec_tab[7]  = '{16'h4017, 8'h44};
    dec_tab[8]  = '{16'h4018, 8'h44};  // open bus: last read was $4017
    dec_tab[9]  = '{16'h401F, 8'h44};
    dec_tab[10] = '{16'h4020, 8'h55};
    dec_tab[11] = '{16'hFFFF, 8'h55};

    ram = 8'h11; ppu = 8'h22; apu = 8'h33; jpd = 8'h44; mmc = 8'h55;
    rstn = 1'b0; cpu_addr = 16'h0300; cpu_r_wn = 1'b0; cpu_wdata = 8'hAB;
    req_f = 2'b00; req_r = 2'b00;
    dma_addr = {16'h0600, 16'h0200}; dma_wn = 2'b11; dma_wdata = 16'hCD99;

    // Reset: CPU write suppressed while reset is asserted.
    tick();
    chk("reset_no_write", 32'(bus_wn_f), 32'h1);
    chk("reset_pause", 32'(pause_f), 32'h0);
    chk("reset_gnt", 32'(gnt_f), 32'h0);
    tick();
    rstn = 1'b1;
    idle(2);

    // Address decode and open bus.
    for (int i = 0; i < 12; i++) begin
      cpu_addr = dec_tab[i].addr;
      cpu_r_wn = 1'b1;
      #1;
      chk($sformatf("dec_rdata_%04h", dec_tab[i].addr), 32'(cpu_rdata_f), 32'(dec_tab[i].exp));
      chk($sformatf("dec_addr_%04h", dec_tab[i].addr), 32'(bus_addr_f), 32'(dec_tab[i].addr));
      tick();
    end
    idle(2);

    // Single master, full 256-cycle burst.
    dma_wn = 2'b11;
    req_f  = 2'b01;
    #1;
    chk("t1_pause_idle", 32'(pause_f), 32'h0);
    tick();
    chk("t1_halt_pause", 32'(pause_f), 32'h1);
    chk("t1_halt_gnt", 32'(gnt_f), 32'h0);
    chk("t1_park_addr", 32'(bus_addr_f), 32'h0000);
    chk("t1_park_wn", 32'(bus_wn_f), 32'h1);
    chk("t1_park_wdata", 32'(bus_wdata_f), 32'h00);
    tick();
    chk("t1_gnt", 32'(gnt_f), 32'h1);
    chk("t1_dma_addr", 32'(bus_addr_f), 32'h0200);
    n = 1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (gnt_f == 2'b01 && pause_f) n++;
      else break;
    end
    chk("t1_burst_len", 32'(n), 32'd256);
    chk("t1_release_pause", 32'(pause_f), 32'h0);
    chk("t1_release_gnt", 32'(gnt_f), 32'h0);
    idle(3);

    // Request during CPU writes: no halt until the first read.
    dma_addr[31:16] = 16'h0400; dma_wn = 2'b01; dma_wdata[15:8] = 8'hCD;
    cpu_addr = 16'h0300; cpu_r_wn = 1'b0; cpu_wdata = 8'hAB; req_f = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t2_wr%0d_pause", i), 32'(pause_f), 32'h0);
      chk($sformatf("t2_wr%0d_wdata", i), 32'(bus_wdata_f), 32'hAB);
      chk($sformatf("t2_wr%0d_addr", i), 32'(bus_addr_f), 32'h0300);
      tick();
    end
    cpu_r_wn = 1'b1;
    #1;
    chk("t2_read_pause", 32'(pause_f), 32'h0);
    tick();
    chk("t2_halt_pause", 32'(pause_f), 32'h1);
    chk("t2_halt_wn", 32'(bus_wn_f), 32'h1);
    tick();
    chk("t2_gnt", 32'(gnt_f), 32'h2);
    chk("t2_dma_addr", 32'(bus_addr_f), 32'h0400);
    chk("t2_dma_wn", 32'(bus_wn_f), 32'h0);
    chk("t2_dma_wdata", 32'(bus_wdata_f), 32'hCD);
    req_f = 2'b00;
    tick();
    chk("t2_rearb_gnt", 32'(gnt_f), 32'h0);
    chk("t2_rearb_pause", 32'(pause_f), 32'h1);
    tick();
    chk("t2_release_pause", 32'(pause_f), 32'h0);
    idle(3);

    // Fixed priority: master 0 keeps the bus until it drops its request.
    dma_addr = {16'h0600, 16'h0200}; dma_wn = 2'b11;
    req_f = 2'b11;
    tick();
    tick();
    chk("t4_gnt0_a", 32'(gnt_f), 32'h1);
    tick();
    chk("t4_gnt0_b", 32'(gnt_f), 32'h1);
    req_f = 2'b10;
    tick();
    chk("t4_rearb_gnt", 32'(gnt_f), 32'h0);
    chk("t4_rearb_pause", 32'(pause_f), 32'h1);
    tick();
    chk("t4_gnt1", 32'(gnt_f), 32'h2);
    chk("t4_gnt1_addr", 32'(bus_addr_f), 32'h0600);
    req_f = 2'b00;
    tick();
    chk("t4_rearb2_gnt", 32'(gnt_f), 32'h0);
    tick();
    chk("t4_release_pause", 32'(pause_f), 32'h0);
    idle(3);

    // Round robin: grants alternate 0, 1, 0 with a REARB cycle between.
    req_r = 2'b01;
    tick();
    chk("t3_halt_pause", 32'(pause_r), 32'h1);
    tick();
    chk("t3_gnt0", 32'(gnt_r), 32'h1);
    req_r = 2'b11;
    tick();
    chk("t3_gnt0_hold", 32'(gnt_r), 32'h1);
    req_r = 2'b10;
    tick();
    chk("t3_rearb1_gnt", 32'(gnt_r), 32'h0);
    req_r = 2'b11;
    tick();
    chk("t3_gnt1", 32'(gnt_r), 32'h2);
    chk("t3_gnt1_addr", 32'(bus_addr_r), 32'h0600);
    req_r = 2'b01;
    tick();
    chk("t3_rearb2_gnt", 32'(gnt_r), 32'h0);
    tick();
    chk("t3_gnt0_again", 32'(gnt_r), 32'h1);
    req_r = 2'b00;
    tick();
    chk("t3_rearb3_pause", 32'(pause_r), 32'h1);
    tick();
    chk("t3_release_pause", 32'(pause_r), 32'h0);
    idle(3);

    // Open bus after a RAM read, and paused CPU reads.
    ram = 8'h5A; cpu_addr = 16'h0100;
    #1;
    chk("t5_ram_read", 32'(cpu_rdata_f), 32'h5A);
    tick();
    cpu_addr = 16'h4018;
    dma_addr[15:0] = 16'h2000; dma_wn = 2'b11; req_f = 2'b01;
    #1;
    chk("t5_open_bus", 32'(cpu_rdata_f), 32'h5A);
    tick();
    cpu_addr = 16'h2000; ram = 8'h77;
    #1;
    chk("t5_paused_cpu", 32'(cpu_rdata_f), 32'h5A);
    chk("t5_park_rdata", 32'(dma_rdata_f), 32'h77);
    tick();
    chk("t5_grant_gnt", 32'(gnt_f), 32'h1);
    chk("t5_dma_rdata", 32'(dma_rdata_f), 32'h22);
    chk("t5_paused_cpu2", 32'(cpu_rdata_f), 32'h5A);
    req_f = 2'b00;
    tick();
    chk("t5_latch_dma", 32'(cpu_rdata_f), 32'h22);
    idle(3);

    // Reset in the middle of a DMA write burst.
    dma_addr[15:0] = 16'h0500; dma_wn = 2'b10; dma_wdata[7:0] = 8'h99; req_f = 2'b01;
    tick();
    tick();
    chk("t6_gnt", 32'(gnt_f), 32'h1);
    chk("t6_dma_wn", 32'(bus_wn_f), 32'h0);
    chk("t6_dma_wdata", 32'(bus_wdata_f), 32'h99);
    tick();
    rstn = 1'b0;
    #1;
    chk("t6_reset_no_write", 32'(bus_wn_f), 32'h1);
    tick();
    chk("t6_reset_gnt", 32'(gnt_f), 32'h0);
    chk("t6_reset_pause", 32'(pause_f), 32'h0);
    rstn = 1'b1; req_f = 2'b00; cpu_addr = 16'h4018;
    #1;
    chk("t6_cpu_owner", 32'(bus_addr_f), 32'h4018);
    chk("t6_latch_clear", 32'(cpu_rdata_f), 32'h00);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
